// File: rtl/video_scandbl_p.sv
// Scandoubler: captures one TV line into a ping-pong buffer and replays it twice at VGA rate.
// Latency: pix_out updates 2 clks after pix_out_stb (RAM read register + output register).
// Backpressure: none; strobes are accepted every clk, excess input pixels are dropped and flag ovf.
module video_scandbl_p #(
    parameter int CH_W     = 2,
    parameter int LINE_LEN = 448,
    parameter int ADDR_W   = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                scanin_start,
    input  logic                pix_in_stb,
    input  logic [3*CH_W-1:0]   pix_in,
    input  logic                scanout_start,
    input  logic                pix_out_stb,
    input  logic                dim_on,
    output logic [3*CH_W-1:0]   pix_out,
    output logic                out_line,
    output logic                ovf
);

    localparam int PIX_W = 3 * CH_W;
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(LINE_LEN);

    logic [PIX_W-1:0]  mem [0:1][0:LINE_LEN-1];

    logic              wbank;
    logic [ADDR_W-1:0] waddr;
    logic              wr_en;
    logic [ADDR_W-1:0] len [0:1];

    logic              rbank;
    logic [ADDR_W-1:0] raddr;
    logic              rd_en;
    logic [ADDR_W-1:0] rlen;
    logic              new_line;

    logic              s1_vld;
    logic              s1_hit;
    logic              s1_dim;
    logic [PIX_W-1:0]  rd_dat;
    logic [PIX_W-1:0]  dim_dat;

    logic              wbank_nxt;
    logic [ADDR_W-1:0] wr_base;
    logic              wr_act;
    logic              ovf_set;
    logic              rbank_nxt;
    logic [ADDR_W-1:0] rlen_nxt;
    logic              fetch_hit;

    // A pixel arriving with scanin_start belongs to the new line at address 0.
    always_comb begin
        wbank_nxt = scanin_start ? ~wbank : wbank;
        wr_base   = scanin_start ? '0 : waddr;
        wr_act    = pix_in_stb && (scanin_start || wr_en) && (wr_base < MAX_ADDR);
        ovf_set   = pix_in_stb && wr_en && !scanin_start && (waddr == MAX_ADDR);
    end

    // The bank just closed by a same-cycle scanin_start has its length still in waddr.
    always_comb begin
        rbank_nxt = ~wbank_nxt;
        rlen_nxt  = scanin_start ? waddr : len[rbank_nxt];
        fetch_hit = pix_out_stb && rd_en && (raddr < rlen);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbank  <= 1'b0;
            waddr  <= '0;
            wr_en  <= 1'b0;
            len[0] <= '0;
            len[1] <= '0;
            ovf    <= 1'b0;
        end else begin
            if (scanin_start) begin
                len[wbank] <= waddr;
                wbank      <= ~wbank;
                wr_en      <= 1'b1;
            end
            if (wr_act) begin
                waddr <= wr_base + ADDR_W'(1);
            end else if (scanin_start) begin
                waddr <= '0;
            end
            if (ovf_set) begin
                ovf <= 1'b1;
            end
        end
    end

    // Line storage is never cleared; len masks stale contents.
    always_ff @(posedge clk) begin
        if (wr_act) begin
            mem[wbank_nxt][wr_base] <= pix_in;
        end
        if (fetch_hit) begin
            rd_dat <= mem[rbank][raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rbank    <= 1'b0;
            raddr    <= '0;
            rd_en    <= 1'b0;
            rlen     <= '0;
            out_line <= 1'b0;
            new_line <= 1'b1;
        end else begin
            if (scanout_start) begin
                rbank    <= rbank_nxt;
                raddr    <= '0;
                rd_en    <= 1'b1;
                rlen     <= rlen_nxt;
                out_line <= (new_line || scanin_start) ? 1'b0 : ~out_line;
                new_line <= 1'b0;
            end else begin
                if (fetch_hit) begin
                    raddr <= raddr + ADDR_W'(1);
                end
                if (scanin_start) begin
                    new_line <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        dim_dat = '0;
        for (int c = 0; c < 3; c++) begin
            dim_dat[c*CH_W +: CH_W] = rd_dat[c*CH_W +: CH_W] >> 1;
        end
    end

    // Misses carry no RAM data, so the output stage substitutes black.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_hit  <= 1'b0;
            s1_dim  <= 1'b0;
            pix_out <= '0;
        end else begin
            s1_vld <= pix_out_stb;
            s1_hit <= fetch_hit;
            s1_dim <= dim_on && out_line;
            if (s1_vld) begin
                pix_out <= !s1_hit ? '0 : (s1_dim ? dim_dat : rd_dat);
            end
        end
    end

endmodule
